rr_select_arbiter: RTL
======================

// Module: rr_select_arbiter
// PURPOSE
//  8-way round-robin arbiter that produces the 3-bit select (s2,s1,s0) consumed by
//  the 3-to-8 decoder stage directly downstream. Picks one active requester fairly,
//  holds its index stable under a valid/ready handshake until accepted, then rotates
//  priority. Decoder outputs are qualified downstream by gnt_valid.
// PARAMETERS
//  N_REQ   8   number of requesters; fixed at 8, matching decoder width
//  IDX_W   3   grant index width; equals log2(N_REQ)
//  CNT_W   8   width of accepted-grant counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  req        in   8      request vector; bit i = requester i
//  gnt_ready  in   1      downstream accepts current grant this cycle
//  gnt_valid  out  1      gnt_idx holds a valid grant
//  gnt_idx    out  3      granted index; [2]=s2, [1]=s1, [0]=s0 to decoder
//  gnt_count  out  CNT_W  number of accepted grants, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, gnt_valid=0, gnt_idx=0, ptr=0,
//   gnt_count=0. Asserting rst mid-OFFER drops the grant immediately; no accept counted.
//  All outputs are registered; no combinational path from req/gnt_ready to outputs.
//  ptr (3 b): highest-priority index. Search order ptr, ptr+1, ..., 7, 0, ..., ptr-1.
//  FSM:
//   IDLE : req==0 -> stay. req!=0 -> gnt_idx<=pick(req,ptr), gnt_valid<=1, ->OFFER.
//          Latency: req seen at edge k, gnt_valid=1 after edge k+1 (1 cycle).
//   OFFER: gnt_valid=1; gnt_idx stable until accept (no retraction, no change).
//          Accept = gnt_valid & gnt_ready. On accept: ptr<=gnt_idx+1 (mod 8, 7->0),
//          gnt_count<=gnt_count+1 (mod 2^CNT_W).
//          Accept & req!=0: gnt_idx<=pick(req, gnt_idx+1), stay OFFER, gnt_valid
//            stays 1 (back-to-back, no bubble). req sampled in accept cycle, incl. the
//            just-granted bit (it wins again only if it is the sole requester).
//          Accept & req==0: gnt_valid<=0, ->IDLE (gnt_idx keeps last value).
//          No accept: stay, regardless of req changes (granted bit may drop; grant held).
//  Arithmetic: all index math 3 b, natural wrap. gnt_count wraps silently to 0.
//  gnt_ready while gnt_valid=0 is ignored. Illegal state encoding recovers to IDLE.
// STRUCTURE
//  Shared include rr_defs.vh: N_REQ, IDX_W, state encodings ST_IDLE=1'b0, ST_OFFER=1'b1.
//  Sub-module rr_pick (combinational): inputs req[7:0], ptr[2:0]; outputs idx[2:0],
//   any; rotate req right by ptr, priority-find lowest set bit, add ptr back mod 8.
//  Top holds FSM, ptr, output regs, counter; instantiates one rr_pick whose ptr input
//   muxes ptr (IDLE) / gnt_idx+1 (accept in OFFER).
// TESTING
//  1 Reset: rst=1 with req=8'hFF -> gnt_valid=0, gnt_idx=0, gnt_count=0; release,
//    one edge later gnt_valid=1, gnt_idx=0.
//  2 Rotation: req=8'hFF, gnt_ready=1 constant -> gnt_idx 0,1,2,...,7,0 on
//    consecutive cycles, gnt_valid never drops, gnt_count=9 after 9 accepts.
//  3 Hold: req=8'b0010_0100, gnt_ready=0 for 5 cycles -> gnt_idx=2 stable, valid=1;
//    drop req[2] meanwhile -> still 2; then ready=1 -> next gnt_idx=5.
//  4 Wrap/search: ptr=6 (after accepting 5), req=8'b0000_0010 -> gnt_idx=1;
//    sole requester 3 re-granted on every accept while req=8'h08.
//  5 Empty: accept with req=0 -> gnt_valid=0 next cycle, state IDLE; new req=8'h80
//    -> gnt_idx=7 one cycle later.
//  6 Reset mid-OFFER: rst pulse between edges while valid=1 -> gnt_valid=0
//    immediately (async), ptr=0, gnt_count=0.

Source files
------------

// File: rtl/rr_select_arbiter_pkg.sv
// Shared sizing and state encodings for the round-robin select arbiter.
package rr_select_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

endpackage

// File: rtl/rr_select_arbiter_pick.sv
// Round-robin pick: first set request bit searching upward from ptr, wrapping at N_REQ.
module rr_select_arbiter_pick
  import rr_select_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  always_comb begin
    rot = '0;
    off = '0;
    // rot[0] is the requester at ptr; index math wraps naturally in IDX_W bits
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[IDX_W'(i) + ptr];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign idx = off + ptr;
  assign any = |req;

endmodule

// File: rtl/rr_select_arbiter.sv
// 8-way round-robin arbiter driving the 3-bit decoder select under a valid/ready handshake.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | no grant outstanding; wait for any request
//  ST_OFFER | gnt_idx offered with gnt_valid=1; held until gnt_ready
module rr_select_arbiter
  import rr_select_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [CNT_W-1:0] gnt_count
);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  assign idx_next = gnt_idx + IDX_W'(1);

  // In OFFER the pick only matters on accept, where the new priority is gnt_idx+1
  assign pick_ptr = (state == ST_OFFER) ? idx_next : ptr;

  rr_select_arbiter_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= '0;
      gnt_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (gnt_valid && gnt_ready) begin
            ptr       <= idx_next;
            gnt_count <= gnt_count + CNT_W'(1);
            if (pick_any) begin
              gnt_idx <= pick_idx;
            end else begin
              gnt_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        default: begin
          gnt_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
